// File: rtl/mem_bridge.sv
// Wait-state bridge between multi_cycle_mips and async_mem.
// Holds memory strobes for the length of each access and pulses ready when it completes.
module mem_bridge #(
  parameter int READ_WAIT = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_read,
  input  logic             cpu_write,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_write_data,
  output logic [31:0]      cpu_read_data,
  output logic             ready,
  output logic             err,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  localparam int WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  // A simultaneous read and write is serviced as a write; misaligned or
  // conflicting requests still proceed but latch the sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      ready          <= 1'b0;
      err            <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      cpu_read_data  <= '0;
      rd_count       <= '0;
      wr_count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_write) begin
            mem_addr       <= {cpu_addr[31:2], 2'b00};
            mem_write_data <= cpu_write_data;
            mem_write      <= 1'b1;
            state          <= WRITE;
            if (cpu_read || (cpu_addr[1:0] != 2'b00)) begin
              err <= 1'b1;
            end
          end else if (cpu_read) begin
            mem_addr <= {cpu_addr[31:2], 2'b00};
            mem_read <= 1'b1;
            wait_cnt <= '0;
            state    <= READ;
            if (cpu_addr[1:0] != 2'b00) begin
              err <= 1'b1;
            end
          end
        end

        READ: begin
          if (wait_cnt == WAIT_LAST) begin
            cpu_read_data <= mem_read_data;
            mem_read      <= 1'b0;
            ready         <= 1'b1;
            rd_count      <= rd_count + CNT_W'(1);
            state         <= DONE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        WRITE: begin
          mem_write <= 1'b0;
          ready     <= 1'b1;
          wr_count  <= wr_count + CNT_W'(1);
          state     <= DONE;
        end

        DONE: begin
          ready <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: a behavioural async_mem plus a transaction-level
// reference model (shadow memory, access counts, sticky error) drive randomized and directed accesses.
module tb_mem_bridge;

  localparam int RW = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_read;
  logic          cpu_write;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_write_data;
  logic [31:0]   cpu_read_data;
  logic          ready;
  logic          err;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] wr_count;

  always #5 clk = ~clk;

  mem_bridge #(.READ_WAIT(RW), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_read      (cpu_read),
    .cpu_write     (cpu_write),
    .cpu_addr      (cpu_addr),
    .cpu_write_data(cpu_write_data),
    .cpu_read_data (cpu_read_data),
    .ready         (ready),
    .err           (err),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data),
    .rd_count      (rd_count),
    .wr_count      (wr_count)
  );

  // Behavioural async_mem: combinational read, write commits on the rising edge.
  logic [31:0] mem [0:255];
  logic        preload;
  logic [7:0]  preload_idx;
  logic [31:0] preload_val;

  always @(posedge clk) begin
    if (preload) mem[preload_idx] <= preload_val;
    else if (mem_write) mem[mem_addr[9:2]] <= mem_write_data;
  end

  assign mem_read_data = mem[mem_addr[9:2]];

  logic [31:0] ref_mem [0:255];
  int          exp_rd;
  int          exp_wr;
  logic        exp_err;
  logic [31:0] last_rdata;
  int          errors;
  int          checks;

  function automatic logic [CW-1:0] cnt_of(input int n);
    return CW'(n % (1 << CW));
  endfunction

  function automatic void model_reset();
    exp_rd     = 0;
    exp_wr     = 0;
    exp_err    = 1'b0;
    last_rdata = 32'h0;
  endfunction

  function automatic void model_access(input logic rd, input logic wr, input logic [31:0] addr,
                                       input logic [31:0] wdata, output int e_lat,
                                       output logic [31:0] e_data);
    int idx;
    idx = int'(addr[9:2]);
    if ((rd && wr) || (addr[1:0] != 2'b00)) exp_err = 1'b1;
    if (wr) begin
      ref_mem[idx] = wdata;
      exp_wr++;
      e_lat  = 1;
      e_data = last_rdata;
    end else begin
      exp_rd++;
      e_lat      = RW;
      e_data     = ref_mem[idx];
      last_rdata = e_data;
    end
  endfunction

  // Presents one request, scrambles address/data after acceptance, and waits (bounded) for ready.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, output int lat, output int strobes,
                            output logic [31:0] rdata);
    @(negedge clk);
    cpu_read       = rd;
    cpu_write      = wr;
    cpu_addr       = addr;
    cpu_write_data = wdata;
    lat     = -1;
    strobes = 0;
    rdata   = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        cpu_addr       = $urandom;
        cpu_write_data = $urandom;
      end
      if (ready) begin
        lat   = i - 1;
        rdata = cpu_read_data;
        break;
      end
      if (mem_read || mem_write) strobes++;
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (mem_read !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_read: got %b want 0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_write: got %b want 0", mem_write); end
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b want 0", ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", err); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_write_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_wdata: got %h want 0", mem_write_data); end
    checks++; if (cpu_read_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_cpu_rdata: got %h want 0", cpu_read_data); end
    checks++; if (rd_count !== '0) begin errors++; $display("[TB] FAIL reset_rd_count: got %0d want 0", rd_count); end
    checks++; if (wr_count !== '0) begin errors++; $display("[TB] FAIL reset_wr_count: got %0d want 0", wr_count); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if (ready !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("[TB] FAIL idle_quiet: ready=%b mem_read=%b want 0/0", ready, mem_read); end
  endtask

  task automatic test_read();
    int lat, strobes, e_lat;
    logic [31:0] rdata, e_data;
    model_access(1'b1, 1'b0, 32'h10, 32'h0, e_lat, e_data);
    run_access(1'b1, 1'b0, 32'h10, 32'h0, lat, strobes, rdata);
    checks++; if (lat !== e_lat) begin errors++; $display("[TB] FAIL read_latency: got %0d want %0d", lat, e_lat); end
    checks++; if (strobes !== RW) begin errors++; $display("[TB] FAIL read_strobe_cycles: got %0d want %0d", strobes, RW); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_data: got %h want deadbeef", rdata); end
    checks++; if (rd_count !== cnt_of(exp_rd)) begin errors++; $display("[TB] FAIL read_rd_count: got %0d want %0d", rd_count, cnt_of(exp_rd)); end
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL ready_one_cycle: got %b want 0", ready); end
    checks++; if (cpu_read_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_data_held: got %h want deadbeef", cpu_read_data); end
  endtask

  task automatic test_write_read();
    int lat, strobes, e_lat;
    logic [31:0] rdata, e_data;
    model_access(1'b0, 1'b1, 32'h20, 32'h12345678, e_lat, e_data);
    run_access(1'b0, 1'b1, 32'h20, 32'h12345678, lat, strobes, rdata);
    checks++; if (lat !== e_lat) begin errors++; $display("[TB] FAIL write_latency: got %0d want %0d", lat, e_lat); end
    checks++; if (strobes !== 1) begin errors++; $display("[TB] FAIL write_strobe_cycles: got %0d want 1", strobes); end
    checks++; if (mem[8] !== 32'h12345678) begin errors++; $display("[TB] FAIL write_mem_word8: got %h want 12345678", mem[8]); end
    checks++; if (wr_count !== cnt_of(exp_wr)) begin errors++; $display("[TB] FAIL write_wr_count: got %0d want %0d", wr_count, cnt_of(exp_wr)); end
    model_access(1'b1, 1'b0, 32'h20, 32'h0, e_lat, e_data);
    run_access(1'b1, 1'b0, 32'h20, 32'h0, lat, strobes, rdata);
    checks++; if (rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL readback_data: got %h want 12345678", rdata); end
    checks++; if (rd_count !== cnt_of(exp_rd)) begin errors++; $display("[TB] FAIL readback_rd_count: got %0d want %0d", rd_count, cnt_of(exp_rd)); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL clean_err: got %b want 0", err); end
  endtask

  task automatic test_misaligned_conflict();
    int lat, strobes, e_lat;
    logic [31:0] rdata, e_data;
    model_access(1'b1, 1'b0, 32'h13, 32'h0, e_lat, e_data);
    run_access(1'b1, 1'b0, 32'h13, 32'h0, lat, strobes, rdata);
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL misaligned_data: got %h want deadbeef", rdata); end
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL misaligned_err: got %b want 1", err); end
    repeat (3) @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %b want 1", err); end
    model_access(1'b1, 1'b1, 32'h30, 32'hA5A5_0F0F, e_lat, e_data);
    run_access(1'b1, 1'b1, 32'h30, 32'hA5A5_0F0F, lat, strobes, rdata);
    checks++; if (lat !== e_lat) begin errors++; $display("[TB] FAIL conflict_latency: got %0d want %0d", lat, e_lat); end
    checks++; if (mem[12] !== 32'hA5A5_0F0F) begin errors++; $display("[TB] FAIL conflict_mem_word12: got %h want a5a50f0f", mem[12]); end
    checks++; if (rd_count !== cnt_of(exp_rd) || wr_count !== cnt_of(exp_wr)) begin errors++; $display("[TB] FAIL conflict_counts: got rd=%0d wr=%0d want rd=%0d wr=%0d", rd_count, wr_count, cnt_of(exp_rd), cnt_of(exp_wr)); end
    checks++; if (err !== exp_err) begin errors++; $display("[TB] FAIL conflict_err: got %b want %b", err, exp_err); end
  endtask

  task automatic test_back_to_back();
    int pulses, prev, extra, e_lat;
    logic [31:0] e_data;
    pulses = 0;
    prev   = -1;
    extra  = 0;
    for (int n = 0; n < 3; n++) model_access(1'b1, 1'b0, 32'h40, 32'h0, e_lat, e_data);
    @(negedge clk);
    cpu_read = 1'b1;
    cpu_addr = 32'h40;
    for (int i = 1; i <= 40 && pulses < 3; i++) begin
      @(negedge clk);
      if (ready) begin
        pulses++;
        if (prev >= 0) begin
          checks++; if (i - prev !== RW + 2) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d want %0d", i - prev, RW + 2); end
        end
        prev = i;
      end
    end
    cpu_read = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready) extra++;
    end
    checks++; if (pulses !== 3 || extra !== 0) begin errors++; $display("[TB] FAIL b2b_pulses: got %0d (+%0d extra) want 3", pulses, extra); end
    checks++; if (rd_count !== cnt_of(exp_rd)) begin errors++; $display("[TB] FAIL b2b_rd_count: got %0d want %0d", rd_count, cnt_of(exp_rd)); end
    checks++; if (cpu_read_data !== e_data) begin errors++; $display("[TB] FAIL b2b_data: got %h want %h", cpu_read_data, e_data); end
  endtask

  task automatic test_reset_mid_access();
    int seen;
    logic [31:0] newval;
    @(negedge clk);
    cpu_read = 1'b1;
    cpu_addr = 32'h44;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (mem_read !== 1'b1) begin errors++; $display("[TB] FAIL midread_strobe: got %b want 1", mem_read); end
    reset    = 1'b1;
    cpu_read = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("[TB] FAIL midread_async_drop: got %b want 0", mem_read); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    seen  = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ready || mem_read) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL midread_no_ready: got %0d active cycles want 0", seen); end
    checks++; if (rd_count !== 2'd0 || cpu_read_data !== 32'h0) begin errors++; $display("[TB] FAIL midread_not_counted: got rd=%0d data=%h want 0/0", rd_count, cpu_read_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_clears_err: got %b want 0", err); end

    newval = ~ref_mem[20];
    @(negedge clk);
    cpu_write      = 1'b1;
    cpu_addr       = 32'h50;
    cpu_write_data = newval;
    @(posedge clk);
    #1;
    checks++; if (mem_write !== 1'b1) begin errors++; $display("[TB] FAIL midwrite_strobe: got %b want 1", mem_write); end
    reset     = 1'b1;
    cpu_write = 1'b0;
    #1;
    checks++; if (mem_write !== 1'b0) begin errors++; $display("[TB] FAIL midwrite_async_drop: got %b want 0", mem_write); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    checks++; if (mem[20] !== ref_mem[20]) begin errors++; $display("[TB] FAIL midwrite_not_issued: got %h want %h", mem[20], ref_mem[20]); end
    checks++; if (wr_count !== 2'd0) begin errors++; $display("[TB] FAIL midwrite_not_counted: got %0d want 0", wr_count); end
  endtask

  task automatic test_counter_wrap();
    int lat, strobes, e_lat;
    logic [31:0] rdata, e_data, wdata, addr;
    for (int n = 0; n < 4; n++) begin
      addr  = 32'h100 + 32'(n * 4);
      wdata = $urandom;
      model_access(1'b0, 1'b1, addr, wdata, e_lat, e_data);
      run_access(1'b0, 1'b1, addr, wdata, lat, strobes, rdata);
      if (n == 2) begin
        checks++; if (wr_count !== 2'd3) begin errors++; $display("[TB] FAIL wrap_max: got %0d want 3", wr_count); end
      end
    end
    checks++; if (wr_count !== 2'd0) begin errors++; $display("[TB] FAIL wrap_zero: got %0d want 0", wr_count); end
    checks++; if (wr_count !== cnt_of(exp_wr)) begin errors++; $display("[TB] FAIL wrap_model: got %0d want %0d", wr_count, cnt_of(exp_wr)); end
  endtask

  task automatic test_random();
    int lat, strobes, e_lat, kind, idx;
    logic rd, wr;
    logic [31:0] rdata, e_data, addr, wdata;
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 9));
      rd   = (kind <= 4) || (kind == 9);
      wr   = (kind >= 5);
      addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      wdata = $urandom;
      idx   = int'(addr[9:2]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      model_access(rd, wr, addr, wdata, e_lat, e_data);
      run_access(rd, wr, addr, wdata, lat, strobes, rdata);
      checks++; if (lat !== e_lat) begin errors++; $display("[TB] FAIL rand_latency[%0d]: got %0d want %0d", n, lat, e_lat); end
      checks++; if (strobes !== e_lat) begin errors++; $display("[TB] FAIL rand_strobes[%0d]: got %0d want %0d", n, strobes, e_lat); end
      if (wr) begin
        checks++; if (mem[idx] !== ref_mem[idx]) begin errors++; $display("[TB] FAIL rand_wmem[%0d]: got %h want %h", n, mem[idx], ref_mem[idx]); end
        checks++; if (cpu_read_data !== e_data) begin errors++; $display("[TB] FAIL rand_rdata_held[%0d]: got %h want %h", n, cpu_read_data, e_data); end
      end else begin
        checks++; if (rdata !== e_data) begin errors++; $display("[TB] FAIL rand_rdata[%0d]: got %h want %h", n, rdata, e_data); end
      end
      checks++; if (rd_count !== cnt_of(exp_rd) || wr_count !== cnt_of(exp_wr)) begin errors++; $display("[TB] FAIL rand_counts[%0d]: got rd=%0d wr=%0d want rd=%0d wr=%0d", n, rd_count, wr_count, cnt_of(exp_rd), cnt_of(exp_wr)); end
      checks++; if (err !== exp_err) begin errors++; $display("[TB] FAIL rand_err[%0d]: got %b want %b", n, err, exp_err); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    errors         = 0;
    checks         = 0;
    reset          = 1'b1;
    cpu_read       = 1'b0;
    cpu_write      = 1'b0;
    cpu_addr       = 32'h0;
    cpu_write_data = 32'h0;
    preload        = 1'b0;
    preload_idx    = 8'h0;
    preload_val    = 32'h0;
    model_reset();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      preload     = 1'b1;
      preload_idx = i[7:0];
      preload_val = (i == 4) ? 32'hDEADBEEF : $urandom;
      ref_mem[i]  = preload_val;
    end
    @(negedge clk);
    preload = 1'b0;

    test_reset();
    test_read();
    test_write_read();
    test_misaligned_conflict();
    test_back_to_back();
    test_reset_mid_access();
    test_counter_wrap();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
# mem_bridge

Wait-state memory bridge between `multi_cycle_mips` and `async_mem`. It accepts one word read or write from the CPU and drives the memory strobes for exactly as long as the access needs. Reads are held for a fixed number of wait cycles that covers the 7 ns memory access time, then the returned word is captured into a register. Completion is signalled with a one-cycle `ready` pulse, so the CPU FSM can stall on `ready` instead of relying on combinational memory timing.

## Interface
Parameters:
- `READ_WAIT`, default 3: cycles `mem_read` is held before data capture. Must be ≥ 1. The value 3 covers 7 ns access at a 2.5 ns clock.
- `CNT_W`, default 16: width of each access counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cpu_read` in 1: CPU read request, level.
- `cpu_write` in 1: CPU write request, level.
- `cpu_addr` in 32: byte address.
- `cpu_write_data` in 32: store data.
- `cpu_read_data` out 32: registered load data, valid while `ready`=1 and held until the next read completes.
- `ready` out 1: one-cycle completion pulse.
- `err` out 1: sticky protocol/alignment error.
- `mem_read` out 1: to `async_mem.read`.
- `mem_write` out 1: to `async_mem.write`.
- `mem_addr` out 32: to `async_mem.address`.
- `mem_write_data` out 32: to `async_mem.write_data`.
- `mem_read_data` in 32: from `async_mem.read_data`.
- `rd_count` out CNT_W: completed reads.
- `wr_count` out CNT_W: completed writes.

## Operation
- All outputs are registered.
- Reset values: state IDLE; `mem_read`, `mem_write`, `ready` and `err` = 0; `mem_addr`, `mem_write_data` and `cpu_read_data` = 0; both counters = 0.

States and transitions:
- IDLE: samples `cpu_read`/`cpu_write` every edge.
  - Read request: latch `{cpu_addr[31:2],2'b00}` into `mem_addr`, set `mem_read`=1, clear the wait counter, go to READ.
  - Write request: also latch `cpu_write_data` into `mem_write_data`, set `mem_write`=1, go to WRITE.
- READ: `mem_read` and `mem_addr` are held stable. The wait counter increments each edge. On the edge where it equals READ_WAIT-1:
  - capture `mem_read_data` into `cpu_read_data`;
  - clear `mem_read`, set `ready`=1;
  - increment `rd_count`;
  - go to DONE.
- WRITE: lasts exactly one cycle, so memory commits on that edge. On that edge clear `mem_write`, set `ready`=1, increment `wr_count`, go to DONE.
- DONE: `ready`=1 for this one cycle only. Requests are ignored. Next edge: clear `ready`, go to IDLE.

Rules:
- The CPU holds its request until it sees `ready`, then drops it or presents the next request. A request still high in IDLE starts a new transaction.
- Simultaneous `cpu_read` and `cpu_write` in IDLE: serviced as a write, and `err` is set.
- `cpu_addr[1:0]` ≠ 0 at acceptance: the access proceeds on the aligned-down word, and `err` is set.
- `err` clears only on reset.
- Request inputs are ignored outside IDLE, even if they change mid-transaction.
- Counters wrap from 2^CNT_W−1 to 0.

## Timing
- Acceptance edge k:
  - Read: `mem_read` is high for cycles k..k+READ_WAIT−1. Data is captured at edge k+READ_WAIT. `ready` is high from k+READ_WAIT to k+READ_WAIT+1. The next acceptance is possible at edge k+READ_WAIT+2.
  - Write: `mem_write` is high for exactly cycle k..k+1. `ready` is high from k+1 to k+2. The next acceptance is possible at k+3.
- Default throughput: a read occupies 5 edges and a write 3 edges.
- Asynchronous reset mid-transaction:
  - all strobes drop immediately and the FSM returns to IDLE;
  - a write whose `mem_write` is cleared before its commit edge is never issued;
  - the partial read is not captured and is not counted.
- Reset deasserts with no clock edge pending. The first acceptance happens on the first rising edge with reset low.

## Test plan
- Read: memory word 4 = 0xDEADBEEF. Hold `cpu_read` with addr 0x10 → `mem_read` high 3 cycles; `ready` pulses once 3 edges after acceptance; `cpu_read_data`=0xDEADBEEF; `rd_count`=1.
- Write then read: write 0x12345678 to 0x20, then read 0x20 → `mem_write` high exactly 1 cycle; `mem_data[8]`=0x12345678; the read returns 0x12345678; `wr_count`=1, `rd_count`=1.
- Misaligned/conflict: read addr 0x13 → data from word 4, `err`=1 and stays set. Separately, read and write together at 0x30 → a write occurs at word 12, `err`=1.
- Back-to-back: hold `cpu_read` high across 3 accesses → exactly 3 `ready` pulses, each 5 edges apart; `rd_count`=3.
- Reset mid-read and counter wrap:
  - Assert `reset` one cycle into READ → `mem_read` drops within the same cycle, FSM returns to IDLE, `ready` never pulses, `rd_count`=0.
  - With CNT_W=2, 4 writes → `wr_count`=0.
